// File: rtl/rand_target_picker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rand_target_picker_pkg
// Brief   : Shared game constants: picker FSM encoding, grid defaults, sizing.
// Revision: 1.0 - initial release
// ============================================================================
package rand_target_picker_pkg;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_SAMPLE = 2'd1;
    localparam logic [1:0] STATE_HOLD   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = STATE_IDLE,
        ST_SAMPLE = STATE_SAMPLE,
        ST_HOLD   = STATE_HOLD
    } picker_state_t;

    // Default 3x3 target grid
    localparam int GRID_RANGE  = 9;
    localparam int GRID_PICK_W = 4;

    // Bits needed to hold values 0..value-1 (minimum 1)
    function automatic int clog2_f(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rand_target_picker_if.sv
`default_nettype none
// ============================================================================
// Module  : rand_target_picker_if
// Brief   : Random feed, request and pick valid/ready handshake bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface rand_target_picker_if
    import rand_target_picker_pkg::*;
#(
    parameter int PICK_W = GRID_PICK_W
);
    logic [15:0]       random;
    logic              req;
    logic              pick_valid;
    logic              pick_ready;
    logic [PICK_W-1:0] pick;
    logic              fallback;
    logic              busy;

    modport master (
        input  random, req, pick_ready,
        output pick_valid, pick, fallback, busy
    );

    modport slave (
        output random, req, pick_ready,
        input  pick_valid, pick, fallback, busy
    );
endinterface
`default_nettype wire

// File: rtl/rand_target_picker.sv
`default_nettype none
// ============================================================================
// Module  : rand_target_picker
// Brief   : Rejection-sampled uniform target index from an LFSR word, with
//           optional no-repeat and a deterministic fallback after MAX_TRIES.
// Revision: 1.0 - initial release
// ============================================================================
module rand_target_picker
    import rand_target_picker_pkg::*;
#(
    parameter int RANGE     = GRID_RANGE,
    parameter int PICK_W    = GRID_PICK_W,
    parameter int MAX_TRIES = 8,
    parameter int NO_REPEAT = 1
) (
    input  wire logic              system_clk,
    input  wire logic              rst,
    rand_target_picker_if.master   bus
);

    localparam int                TRY_W     = clog2_f(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]  TRY_LIMIT = TRY_W'(MAX_TRIES);
    localparam logic [PICK_W:0]   RANGE_EXT = (PICK_W+1)'(RANGE);
    localparam logic [PICK_W-1:0] LAST_IDX  = PICK_W'(RANGE - 1);

    picker_state_t     r_state, w_state_nxt;
    logic [TRY_W-1:0]  r_tries, w_tries_nxt;
    logic [PICK_W-1:0] r_pick, w_pick_nxt;
    logic              r_fallback, w_fallback_nxt;
    logic [PICK_W-1:0] r_last_pick, w_last_pick_nxt;
    logic              r_last_valid, w_last_valid_nxt;

    logic [PICK_W-1:0] w_cand;
    logic [PICK_W-1:0] w_fb_pick;
    logic              w_in_range;
    logic              w_is_repeat;
    logic              w_accept;
    logic              w_unused_random;

    assign w_cand          = bus.random[PICK_W-1:0];
    assign w_unused_random = ^bus.random[15:PICK_W];

    // Extra bit lets RANGE equal 2^PICK_W, where every candidate is legal
    assign w_in_range  = ({1'b0, w_cand} < RANGE_EXT);
    assign w_is_repeat = (NO_REPEAT != 0) && r_last_valid && (w_cand == r_last_pick);
    assign w_accept    = w_in_range && !w_is_repeat;
    assign w_fb_pick   = !r_last_valid             ? '0 :
                         (r_last_pick == LAST_IDX) ? '0 : r_last_pick + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_tries_nxt      = r_tries;
        w_pick_nxt       = r_pick;
        w_fallback_nxt   = r_fallback;
        w_last_pick_nxt  = r_last_pick;
        w_last_valid_nxt = r_last_valid;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_state_nxt = ST_SAMPLE;
                    w_tries_nxt = '0;
                end
            end
            ST_SAMPLE: begin
                if (r_tries == TRY_LIMIT) begin
                    w_pick_nxt     = w_fb_pick;
                    w_fallback_nxt = 1'b1;
                    w_state_nxt    = ST_HOLD;
                end else if (w_accept) begin
                    w_pick_nxt     = w_cand;
                    w_fallback_nxt = 1'b0;
                    w_state_nxt    = ST_HOLD;
                end else begin
                    w_tries_nxt = r_tries + 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.pick_ready) begin
                    w_last_pick_nxt  = r_pick;
                    w_last_valid_nxt = 1'b1;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tries      <= '0;
            r_pick       <= '0;
            r_fallback   <= 1'b0;
            r_last_pick  <= '0;
            r_last_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tries      <= w_tries_nxt;
            r_pick       <= w_pick_nxt;
            r_fallback   <= w_fallback_nxt;
            r_last_pick  <= w_last_pick_nxt;
            r_last_valid <= w_last_valid_nxt;
        end
    end

    assign bus.pick_valid = (r_state == ST_HOLD);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.pick       = r_pick;
    assign bus.fallback   = r_fallback;

endmodule
`default_nettype wire

// File: tb/tb_rand_target_picker.sv
`default_nettype none
// ============================================================================
// Module  : tb_rand_target_picker
// Brief   : Scoreboard bench for rand_target_picker, directed cases plus LFSR soak.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rand_target_picker;
    import rand_target_picker_pkg::*;

    localparam int RANGE     = 9;
    localparam int PICK_W    = 4;
    localparam int MAX_TRIES = 8;

    logic system_clk = 1'b0;
    logic rst        = 1'b1;
    always #5 system_clk = ~system_clk;

    rand_target_picker_if #(.PICK_W(PICK_W)) bus();

    rand_target_picker #(
        .RANGE     (RANGE),
        .PICK_W    (PICK_W),
        .MAX_TRIES (MAX_TRIES),
        .NO_REPEAT (1)
    ) dut (
        .system_clk (system_clk),
        .rst        (rst),
        .bus        (bus)
    );

    logic [15:0] rand_drv  = 16'h0000;
    logic [15:0] lfsr      = 16'hACE1;
    bit          soak_mode = 1'b0;
    assign bus.random = soak_mode ? lfsr : rand_drv;

    // Free-running game LFSR (Galois, x^16+x^14+x^13+x^11+1)
    always begin
        @(posedge system_clk);
        #1;
        lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    typedef struct packed {
        logic [PICK_W-1:0] pick;
        logic              fb;
    } exp_t;

    exp_t              exp_q[$];
    int                n_checks = 0;
    int                n_errors = 0;
    int                n_deliv  = 0;
    int                n_soak   = 0;
    int                n_fb     = 0;
    bit                seen[RANGE];
    logic [PICK_W-1:0] prev_pick  = '0;
    bit                prev_valid = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Consumer-side monitor: every accepted pick is scored here
    always @(negedge system_clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else if (bus.pick_valid && bus.pick_ready) begin
            n_deliv++;
            if (soak_mode) begin
                n_soak++;
                check_val("soak_range", 32'(bus.pick < PICK_W'(RANGE)), 1);
                if (prev_valid) check_val("soak_norepeat", 32'(bus.pick != prev_pick), 1);
                if (bus.pick < PICK_W'(RANGE)) seen[bus.pick] = 1'b1;
                if (bus.fallback) n_fb++;
            end else if (exp_q.size() == 0) begin
                check_val("unexpected_pick", 32'(bus.pick_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check_val("pick", 32'(bus.pick), 32'(e.pick));
                check_val("fallback", 32'(bus.fallback), 32'(e.fb));
            end
            prev_pick  = bus.pick;
            prev_valid = 1'b1;
        end
    end

    // One request: random=ra in cycles 1..na after req, rb afterwards
    task automatic run_req(input logic [15:0] ra, input int na, input logic [15:0] rb,
                           input int exp_lat, input logic [PICK_W-1:0] exp_pick,
                           input logic exp_fb, input int hold_n, input bit keep_req);
        int   lat;
        bit   got;
        exp_t dropped;
        exp_q.push_back('{pick: exp_pick, fb: exp_fb});
        @(posedge system_clk); #1;
        bus.req  = 1'b1;
        rand_drv = ra;
        @(posedge system_clk); #1;
        bus.req  = keep_req;
        rand_drv = (na >= 1) ? ra : rb;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= MAX_TRIES + 20) begin
            @(negedge system_clk);
            if (lat == 1) check_val("busy_after_req", 32'(bus.busy), 1);
            if (bus.pick_valid) begin
                got = 1'b1;
            end else begin
                @(posedge system_clk); #1;
                lat++;
                rand_drv = (lat <= na) ? ra : rb;
            end
        end
        if (!got) begin
            check_val("valid_timeout", 32'(bus.pick_valid), 1);
            dropped = exp_q.pop_back();
            bus.req = 1'b0;
            return;
        end
        check_val("latency", 32'(lat), 32'(exp_lat));
        repeat (hold_n) begin
            @(posedge system_clk); #1;
            rand_drv = 16'($urandom);
            @(negedge system_clk);
            check_val("hold_valid", 32'(bus.pick_valid), 1);
            check_val("hold_pick", 32'(bus.pick), 32'(exp_pick));
            check_val("hold_fallback", 32'(bus.fallback), 32'(exp_fb));
        end
        @(posedge system_clk); #1;
        bus.pick_ready = 1'b1;
        @(posedge system_clk); #1;
        bus.pick_ready = 1'b0;
        bus.req        = 1'b0;
        @(negedge system_clk);
        check_val("valid_drop", 32'(bus.pick_valid), 0);
        check_val("busy_drop", 32'(bus.busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d0;
        int  extra;
        int  nseen;
        bit  got;
        bus.req        = 1'b1;
        bus.pick_ready = 1'b0;

        // Reset held two cycles with req asserted
        @(posedge system_clk);
        @(negedge system_clk);
        check_val("rst_valid", 32'(bus.pick_valid), 0);
        check_val("rst_pick", 32'(bus.pick), 0);
        check_val("rst_fallback", 32'(bus.fallback), 0);
        check_val("rst_busy", 32'(bus.busy), 0);
        @(posedge system_clk); #1;
        rst     = 1'b0;
        bus.req = 1'b0;
        repeat (3) begin
            @(negedge system_clk);
            check_val("idle_busy", 32'(bus.busy | bus.pick_valid), 0);
        end

        // Fallback with no prior pick, then ordinary flow
        run_req(16'h000F, 99, 16'h000F, MAX_TRIES + 2, 4'd0, 1'b1, 0, 1'b0);
        run_req(16'h0005, 99, 16'h0005, 2, 4'd5, 1'b0, 10, 1'b0);
        run_req(16'h0005, 3, 16'h0007, 5, 4'd7, 1'b0, 0, 1'b0);
        run_req(16'h0009, 2, 16'hFFF8, 4, 4'd8, 1'b0, 0, 1'b0);
        run_req(16'h000F, 99, 16'h000F, MAX_TRIES + 2, 4'd0, 1'b1, 0, 1'b0);
        run_req(16'hABC3, 99, 16'hABC3, 2, 4'd3, 1'b0, 0, 1'b0);
        run_req(16'h000C, 99, 16'h000C, MAX_TRIES + 2, 4'd4, 1'b1, 0, 1'b0);
        run_req(16'h0004, 99, 16'h0004, MAX_TRIES + 2, 4'd5, 1'b1, 0, 1'b0);

        // req held through SAMPLE, HOLD and the handshake edge
        d0 = n_deliv;
        run_req(16'h000F, 2, 16'h0002, 4, 4'd2, 1'b0, 3, 1'b1);
        extra = 0;
        repeat (12) begin
            @(negedge system_clk);
            if (bus.pick_valid || bus.busy) extra++;
        end
        check_val("no_requeue", 32'(extra), 0);
        check_val("one_delivery", 32'(n_deliv - d0), 1);

        // Reset in the middle of SAMPLE
        d0       = n_deliv;
        rand_drv = 16'h000F;
        @(posedge system_clk); #1;
        bus.req = 1'b1;
        @(posedge system_clk); #1;
        bus.req = 1'b0;
        @(posedge system_clk);
        @(posedge system_clk); #1;
        rst = 1'b1;
        @(negedge system_clk);
        check_val("midrst_busy", 32'(bus.busy), 1);
        @(posedge system_clk); #1;
        rst = 1'b0;
        @(negedge system_clk);
        check_val("postrst_busy", 32'(bus.busy), 0);
        extra = 0;
        repeat (12) begin
            @(negedge system_clk);
            if (bus.pick_valid) extra++;
        end
        check_val("postrst_no_pick", 32'(extra + n_deliv - d0), 0);
        run_req(16'h0002, 99, 16'h0002, 2, 4'd2, 1'b0, 0, 1'b0);

        // Soak against the live LFSR with an always-ready consumer
        soak_mode      = 1'b1;
        bus.pick_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge system_clk);
            @(posedge system_clk); #1;
            bus.req = 1'b1;
            @(posedge system_clk); #1;
            bus.req = 1'b0;
            got = 1'b0;
            for (int c = 0; c < MAX_TRIES + 20 && !got; c++) begin
                @(negedge system_clk);
                if (bus.pick_valid) got = 1'b1;
                else @(posedge system_clk);
            end
            if (!got) begin
                check_val("soak_timeout", 32'(bus.pick_valid), 1);
                break;
            end
            @(posedge system_clk);
        end
        #1;
        bus.pick_ready = 1'b0;
        repeat (2) @(negedge system_clk);
        nseen = 0;
        for (int v = 0; v < RANGE; v++) if (seen[v]) nseen++;
        check_val("soak_count", 32'(n_soak), 2000);
        check_val("soak_all_values", 32'(nseen), 32'(RANGE));
        check_val("soak_fallback_rate", 32'(n_fb * 20 < n_soak), 1);
        check_val("queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rand_target_picker.md
Name: rand_target_picker

Overview:
- Consumes the free-running 16-bit random word from the game's LFSR generator, which advances every system_clk.
- On request, produces one target index uniformly in [0, RANGE), using rejection sampling on the low PICK_W bits.
- Optionally forbids repeating the previously delivered index.
- Sits between the LFSR and the game controller that spawns targets (mole/button/LED slot); the controller consumes picks through a valid/ready handshake.

Parameters:
- RANGE, 9: number of legal target indices, 0..RANGE-1. Legal values: 2 <= RANGE <= 2^PICK_W.
- PICK_W, 4: width of the pick output and of the random slice examined.
- MAX_TRIES, 8: rejected samples allowed before a deterministic fallback (>= 1).
- NO_REPEAT, 1: when 1, a pick equal to the last delivered pick is rejected.

Ports:
- system_clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- random  in  16  LFSR word; a new value each cycle
- req  in  1  request one pick; sampled only in IDLE
- pick_valid  out  1  pick is available
- pick_ready  in  1  consumer accepts the pick
- pick  out  PICK_W  target index
- fallback  out  1  qualifies pick: deterministic fallback was used
- busy  out  1  high in SAMPLE or HOLD

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE, pick_valid=0, pick=0, fallback=0, busy=0;
  - try counter=0, last_pick=0, last_valid=0.
- Reset has priority over every other event, including mid-SAMPLE and mid-HOLD. No pick is delivered after it.
- FSM states: IDLE, SAMPLE, HOLD.
- IDLE:
  - req=1 -> SAMPLE, try counter cleared.
  - req=0 -> stay in IDLE.
- SAMPLE: each cycle, candidate c = random[PICK_W-1:0], evaluated combinationally against the current random.
  - Accept if c < RANGE and NOT (NO_REPEAT && last_valid && c == last_pick).
  - On accept: register pick=c, fallback=0, go to HOLD.
  - On reject: increment the try counter.
  - If the counter reaches MAX_TRIES: register pick=F, fallback=1, go to HOLD.
  - F = (last_pick+1) mod RANGE if last_valid, else 0.
- HOLD:
  - pick_valid=1; pick and fallback are held stable while pick_ready=0.
  - On pick_valid && pick_ready: last_pick<=pick, last_valid<=1, go to IDLE. pick_valid drops the next cycle.
- busy=1 exactly when state != IDLE.
- req outside IDLE is ignored; it is not queued, including req coincident with the HOLD handshake. The consumer must re-request.
- Latency:
  - req at edge n; first sample evaluated in cycle n+1; accept at edge n+1 gives pick_valid=1 from cycle n+2.
  - Each rejected sample adds 1 cycle.
  - Worst case, req to pick_valid = MAX_TRIES+2 cycles.
- Widths:
  - The comparison c < RANGE uses PICK_W+1 bits so that RANGE = 2^PICK_W is legal (every c accepted).
  - Modulo for F is implemented as a compare-and-wrap: last_pick == RANGE-1 -> 0. No divider.
- random bits above PICK_W-1 are unused by this block.

Decomposition:
- Shared game package holds:
  - FSM state encoding localparams (IDLE=2'd0, SAMPLE=2'd1, HOLD=2'd2);
  - the default RANGE/PICK_W pair used by the game's grid;
  - a CLOG2-style constant function for sizing the try counter.
- Single module. The accept/reject check is simple enough to stay inline; no sub-module.

Test Plan:
- Reset: assert rst 2 cycles with req=1 -> pick_valid=0, pick=0, fallback=0, busy=0. After release, IDLE with busy=0 until req.
- Direct accept: random=16'h0005 constant; req pulse at edge 0 -> busy=1 from cycle 1; pick_valid=1, pick=5, fallback=0 from cycle 2. Hold pick_ready=0 for 10 cycles -> outputs stable. pick_ready=1 -> pick_valid=0 next cycle.
- No-repeat: after delivering 5, req with random=16'h0005 for 3 cycles then 16'h0007 -> pick=7, fallback=0, pick_valid at cycle 5 after req.
- Fallback exhaustion: last delivered pick=8, random=16'h000F constant (15 >= 9), MAX_TRIES=8 -> pick_valid at cycle 10 after req, pick=0, fallback=1. Repeat with no prior pick after reset -> pick=0, fallback=1.
- Robustness:
  - req pulses during SAMPLE and HOLD -> exactly one pick delivered.
  - rst asserted mid-SAMPLE -> IDLE next cycle, no pick_valid; next pick may equal the pre-reset last pick.
- Soak with the live 16-bit LFSR connected, consumer ready=1, 2000 requests:
  - every pick in 0..8;
  - no two consecutive picks equal;
  - all 9 values observed;
  - fallback count < 5% of picks.
